// File: rtl/clb_cfg_param.sv
// clb_cfg_param: WIDTH-bit ADD/SUB/AND/XOR logic cell with serial config chain and 1/2-stage pipeline
//
// Ports:
//   i_clk         fabric clock, all state on rising edge
//   i_reset       asynchronous active-high reset, clears all state
//   i_cfg_en      shift enable for the config chain
//   i_cfg_din     serial config bit in (MSB first)
//   i_cfg_commit  copy shadow config into active config, flushes the pipeline
//   o_cfg_dout    serial config bit out = shadow[2], chains to the next CLB
//   i_in_valid    i_a/i_b/i_cin valid this cycle
//   i_a, i_b      WIDTH-bit operands
//   i_cin         carry in (ADD only)
//   o_sum_out     WIDTH-bit result
//   o_cout_out    carry / no-borrow out
//   o_out_valid   o_sum_out/o_cout_out valid this cycle
//
// Config word: [1:0] op (00 ADD, 01 SUB, 10 AND, 11 XOR), [2] stages (0 = 1 stage, 1 = 2 stages).
module clb_cfg_param #(
    parameter int         WIDTH     = 2,
    parameter logic [2:0] RESET_CFG = 3'b000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cfg_en,
    input  logic             i_cfg_din,
    input  logic             i_cfg_commit,
    output logic             o_cfg_dout,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum_out,
    output logic             o_cout_out,
    output logic             o_out_valid
);
    logic [2:0]       r_shadow;
    logic [2:0]       r_active;
    logic [WIDTH-1:0] r_sum1;
    logic [WIDTH-1:0] r_sum2;
    logic             r_cout1;
    logic             r_cout2;
    logic             r_v1;
    logic             r_v2;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_res;
    logic             w_take1;
    logic             w_take2;

    assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    // Two's-complement subtract: carry out of a + ~b + 1 is the no-borrow flag
    assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_res = r_active[1:0] == 2'b00 ? w_add :
                r_active[1:0] == 2'b01 ? w_sub :
                r_active[1:0] == 2'b10 ? {1'b0, i_a & i_b} :
                                         {1'b0, i_a ^ i_b};
    end

    // A commit flushes the pipeline: nothing is captured and both valids clear
    assign w_take1 = i_in_valid & ~i_cfg_commit;
    assign w_take2 = r_v1 & ~i_cfg_commit;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shadow <= 3'b000;
            r_active <= RESET_CFG;
            r_sum1   <= '0;
            r_sum2   <= '0;
            r_cout1  <= 1'b0;
            r_cout2  <= 1'b0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
        end else begin
            if (i_cfg_en) r_shadow <= {r_shadow[1:0], i_cfg_din};
            if (i_cfg_commit) r_active <= r_shadow;
            r_v1 <= w_take1;
            r_v2 <= w_take2;
            if (w_take1) {r_cout1, r_sum1} <= w_res;
            if (w_take2) {r_cout2, r_sum2} <= {r_cout1, r_sum1};
        end
    end

    assign o_cfg_dout  = r_shadow[2];
    assign o_sum_out   = r_active[2] ? r_sum2  : r_sum1;
    assign o_cout_out  = r_active[2] ? r_cout2 : r_cout1;
    assign o_out_valid = r_active[2] ? r_v2    : r_v1;
endmodule

// File: tb/tb_clb_cfg_param.sv
// tb_clb_cfg_param: two chained CLBs checked against a latency-queue reference model
module tb_clb_cfg_param;
    localparam int W = 2;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         din = 1'b0;
    logic         cm = 1'b0;
    logic         iv = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         d0, d1, c0, c1, v0, v1;
    logic [W-1:0] s0, s1;

    clb_cfg_param #(.WIDTH(W), .RESET_CFG(3'b000)) u0 (
        .i_clk(clk), .i_reset(rst), .i_cfg_en(en), .i_cfg_din(din), .i_cfg_commit(cm),
        .o_cfg_dout(d0), .i_in_valid(iv), .i_a(a), .i_b(b), .i_cin(cin),
        .o_sum_out(s0), .o_cout_out(c0), .o_out_valid(v0)
    );
    clb_cfg_param #(.WIDTH(W), .RESET_CFG(3'b000)) u1 (
        .i_clk(clk), .i_reset(rst), .i_cfg_en(en), .i_cfg_din(d0), .i_cfg_commit(cm),
        .o_cfg_dout(d1), .i_in_valid(iv), .i_a(a), .i_b(b), .i_cin(cin),
        .o_sum_out(s1), .o_cout_out(c1), .o_out_valid(v1)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int e = 0;
    int sh[2], act[2], ls[2], lc[2];
    bit hok[2];
    bit ev[2][4];
    int es[2][4], ec[2][4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void mreset();
        for (int k = 0; k < 2; k++) begin
            sh[k] = 0; act[k] = 0; ls[k] = 0; lc[k] = 0; hok[k] = 1'b1;
            for (int j = 0; j < 4; j++) ev[k][j] = 1'b0;
        end
    endfunction

    function automatic void calc(input int op, input int av, input int bv, input int ci,
                                 output int s, output int c);
        int t;
        case (op)
            0: begin t = av + bv + ci; s = t % M; c = (t >= M) ? 1 : 0; end
            1: begin s = (av - bv + M) % M; c = (av >= bv) ? 1 : 0; end
            2: begin s = av & bv; c = 0; end
            default: begin s = av ^ bv; c = 0; end
        endcase
    endfunction

    task automatic tick();
        int dk, d1m, s, c, due;
        bit expv;
        @(posedge clk);
        e++;
        d1m = (sh[0] >> 2) & 1;
        for (int k = 0; k < 2; k++) begin
            dk = (k == 0) ? int'(din) : d1m;
            if (cm) begin
                for (int j = 0; j < 4; j++) ev[k][j] = 1'b0;
                act[k] = sh[k];
                hok[k] = 1'b0;
            end else if (iv) begin
                calc(act[k] & 3, int'(a), int'(b), int'(cin), s, c);
                due = e + ((act[k] >> 2) & 1);
                ev[k][due % 4] = 1'b1; es[k][due % 4] = s; ec[k][due % 4] = c;
            end
            if (en) sh[k] = ((sh[k] << 1) | dk) & 7;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            expv = ev[k][e % 4];
            ev[k][e % 4] = 1'b0;
            chk(k ? "u1.valid" : "u0.valid", k ? v1 : v0, expv);
            chk(k ? "u1.dout" : "u0.dout", k ? d1 : d0, (sh[k] >> 2) & 1);
            if (expv) begin
                chk(k ? "u1.sum" : "u0.sum", k ? s1 : s0, es[k][e % 4]);
                chk(k ? "u1.cout" : "u0.cout", k ? c1 : c0, ec[k][e % 4]);
                ls[k] = es[k][e % 4]; lc[k] = ec[k][e % 4]; hok[k] = 1'b1;
            end else if (hok[k]) begin
                chk(k ? "u1.sum_hold" : "u0.sum_hold", k ? s1 : s0, ls[k]);
                chk(k ? "u1.cout_hold" : "u0.cout_hold", k ? c1 : c0, lc[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic zero_chk();
        chk("rst.s0", s0, 0); chk("rst.c0", c0, 0); chk("rst.v0", v0, 0); chk("rst.d0", d0, 0);
        chk("rst.s1", s1, 0); chk("rst.c1", c1, 0); chk("rst.v1", v1, 0); chk("rst.d1", d1, 0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 mreset();
        zero_chk();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic shift3(input logic [2:0] w);
        en = 1'b1;
        for (int i = 2; i >= 0; i--) begin din = w[i]; tick(); end
        en = 1'b0;
    endtask

    task automatic commit();
        cm = 1'b1; tick(); cm = 1'b0;
    endtask

    task automatic feed(input int av, input int bv, input int ci);
        iv = 1'b1; a = W'(av); b = W'(bv); cin = ci[0];
    endtask

    initial begin
        mreset();
        #1 zero_chk();
        @(negedge clk);
        rst = 1'b0;
        // 1: ADD 1-stage after reset, 3+2+1 = 6
        feed(3, 2, 1); tick();
        chk("t1.sum", s0, 2); chk("t1.cout", c0, 1); chk("t1.valid", v0, 1);
        iv = 1'b0; tick();
        chk("t1.valid_drop", v0, 0); chk("t1.sum_held", s0, 2);
        // 2: SUB 2-stage
        shift3(3'b101); commit();
        feed(1, 2, 1); tick();
        chk("t2.lat", v0, 0);
        feed(3, 1, 0); tick();
        chk("t2.sum_a", s0, 3); chk("t2.cout_a", c0, 0); chk("t2.valid_a", v0, 1);
        iv = 1'b0; tick();
        chk("t2.sum_b", s0, 2); chk("t2.cout_b", c0, 1);
        tick();
        // 3: four back-to-back ADD vectors, 2-stage
        shift3(3'b100); commit();
        for (int i = 0; i < 4; i++) begin feed(i, 3 - i + 1, i & 1); tick(); end
        iv = 1'b0; tick(); tick();
        // 4: commit right after a valid input drops that result
        shift3(3'b011);
        feed(2, 3, 0); tick();
        iv = 1'b0; cm = 1'b1; tick(); cm = 1'b0;
        chk("t4.dropped", v0, 0);
        tick();
        chk("t4.still_dropped", v0, 0);
        feed(2, 3, 0); tick();
        chk("t4.xor_sum", s0, 1); chk("t4.xor_valid", v0, 1);
        iv = 1'b0; tick();
        // 5: chain 110_011
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin din = (i == 0 || i == 1 || i == 4 || i == 5); tick(); end
        en = 1'b0; commit();
        feed(3, 1, 1); tick();
        chk("t5.u0_xor", s0, 2); chk("t5.u0_valid", v0, 1); chk("t5.u1_lat", v1, 0);
        iv = 1'b0; tick();
        chk("t5.u1_and", s1, 1); chk("t5.u1_valid", v1, 1);
        tick();
        // 6: async reset mid-shift with a full 2-stage pipeline
        shift3(3'b100); commit();
        for (int i = 0; i < 3; i++) begin feed(i + 1, i, 1); tick(); end
        en = 1'b1; din = 1'b1; tick();
        do_reset();
        en = 1'b0; iv = 1'b0;
        shift3(3'b011);
        en = 1'b1; din = 1'b1; cm = 1'b1; tick();
        en = 1'b0; cm = 1'b0;
        feed(1, 3, 0); tick();
        chk("t6.old_shadow_xor", s0, 2); chk("t6.valid", v0, 1);
        iv = 1'b0; tick();
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 1) == 1);
            din = $urandom_range(0, 1);
            cm = ($urandom_range(0, 7) == 0);
            iv = ($urandom_range(0, 3) != 0);
            a = W'($urandom_range(0, M - 1));
            b = W'($urandom_range(0, M - 1));
            cin = $urandom_range(0, 1);
            if (i == 200) do_reset();
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
